// File: rtl/stream_slice_sched.sv
// Round-robin scheduler in front of one shared slice-reversal (streaming concat) datapath.
// One grant per cycle, single registered response slot with valid/ready, sticky error and job counter.
module stream_slice_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int SW   = $clog2(DW) + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NREQ-1:0]            i_req_valid,
  output logic [NREQ-1:0]            o_req_ready,
  input  logic [NREQ*DW-1:0]         i_req_data,
  input  logic [NREQ*SW-1:0]         i_req_slice,
  input  logic [NREQ-1:0]            i_req_dir,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [DW-1:0]              o_rsp_data,
  output logic [$clog2(NREQ)-1:0]    o_rsp_id,
  output logic                       o_rsp_err,
  output logic                       o_err_sticky,
  output logic [15:0]                o_job_count
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [DW-1:0]   r_rsp_data;
  logic [IW-1:0]   r_rsp_id;
  logic            r_rsp_err, r_err_sticky;
  logic [15:0]     r_job_count;

  logic            w_can_accept, w_hs, w_gnt_any, w_legal, w_dir;
  logic [IW-1:0]   w_gnt_idx, w_scan;
  logic [DW-1:0]   w_data, w_rev, w_result;
  logic [SW-1:0]   w_slice;
  logic [DW-1:0]   w_cand [1:DW];

  // cyclic first-valid search starting at the round-robin pointer
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int off = 0; off < NREQ; off++) begin
      w_scan = IW'((int'(r_rr_ptr) + off) % NREQ);
      if (!w_gnt_any && i_req_valid[w_scan]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_data   = i_req_data[w_gnt_idx*DW +: DW];
  assign w_slice  = i_req_slice[w_gnt_idx*SW +: SW];
  assign w_dir    = i_req_dir[w_gnt_idx];
  assign w_legal  = (w_slice != '0) && (w_slice <= SW'(DW));
  assign w_rr_nxt = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;

  // one fixed permutation per slice size; slice k lands at [DW-1-k*s -: len]
  for (genvar gs = 1; gs <= DW; gs++) begin : g_s
    logic [DW-1:0] w_r;
    for (genvar gi = 0; gi < DW; gi++) begin : g_b
      localparam int K   = gi / gs;
      localparam int LEN = (DW - K*gs < gs) ? (DW - K*gs) : gs;
      assign w_r[DW - K*gs - LEN + (gi % gs)] = w_data[gi];
    end
    assign w_cand[gs] = w_r;
  end

  always_comb begin
    w_rev = w_data;
    for (int s = 1; s <= DW; s++)
      if (int'(w_slice) == s) w_rev = w_cand[s];
  end

  assign w_result = (w_legal && w_dir) ? w_rev : w_data;

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= EMPTY;
    else          r_state <= w_state_nxt;
  end

  // next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_hs) w_state_nxt = FULL;
      FULL:    if (i_rsp_ready) w_state_nxt = w_hs ? FULL : EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // outputs; grants are masked while in reset
  always_comb begin
    w_can_accept = i_rst_n && ((r_state == EMPTY) || i_rsp_ready);
    w_hs         = w_can_accept && w_gnt_any;
    o_req_ready  = '0;
    if (w_hs) o_req_ready[w_gnt_idx] = 1'b1;
    o_rsp_valid  = (r_state == FULL);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr     <= '0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_rsp_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_job_count  <= '0;
    end else if (w_hs) begin
      r_rr_ptr    <= w_rr_nxt;
      r_rsp_data  <= w_result;
      r_rsp_id    <= w_gnt_idx;
      r_rsp_err   <= !w_legal;
      r_job_count <= r_job_count + 16'd1;
      if (!w_legal) r_err_sticky <= 1'b1;
    end
  end

  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_err    = r_rsp_err;
  assign o_err_sticky = r_err_sticky;
  assign o_job_count  = r_job_count;
endmodule

// File: tb/tb_stream_slice_sched.sv
// Scoreboard bench for stream_slice_sched: expectations queued at request time, popped at response.
module tb_stream_slice_sched;
  localparam int NREQ = 4, DW = 32, SW = 6;

  logic               clk, rst_n;
  logic [NREQ-1:0]    req_valid, req_ready, req_dir;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*SW-1:0] req_slice;
  logic               rsp_valid, rsp_ready, rsp_err, err_sticky;
  logic [DW-1:0]      rsp_data;
  logic [1:0]         rsp_id;
  logic [15:0]        job_count;

  typedef struct { logic [1:0] id; logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];
  int n_checks = 0, n_errors = 0;

  stream_slice_sched #(.NREQ(NREQ), .DW(DW), .SW(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_data(req_data), .i_req_slice(req_slice), .i_req_dir(req_dir),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_id(rsp_id), .o_rsp_err(rsp_err), .o_err_sticky(err_sticky), .o_job_count(job_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // concatenate slices in order: the first appended slice ends up at the MSB
  function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic dir);
    logic [31:0] o;
    int len;
    if (s < 1 || s > 32 || !dir) return d;
    o = '0;
    for (int base = 0; base < 32; base += s) begin
      len = (32 - base < s) ? 32 - base : s;
      o = (o << len) | ((d >> base) & ((32'h1 << len) - 32'h1));
    end
    return o;
  endfunction

  task automatic set_req(input int i, input logic [31:0] d, input int s, input logic dir);
    req_data[i*DW +: DW]  = d;
    req_slice[i*SW +: SW] = SW'(s);
    req_dir[i]            = dir;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
    #1 n_checks++;
    if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_err, err_sticky, job_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got v=%b d=%h id=%0d e=%b s=%b jc=%0d want all zero",
               rsp_valid, rsp_data, rsp_id, rsp_err, err_sticky, job_count);
    end
    req_valid = '0; rst_n = 1'b1;
  endtask

  task automatic test_single_requests();
    logic [31:0] d[9]; int s[9]; logic dr[9]; logic [31:0] ex[9];
    exp_t e; int n;
    d  = '{32'h04030201, 32'h04030201, 32'hd70a4497, 32'h04030201, 32'hd70a4497, 32'h00000001, 0, 0, 0};
    s  = '{1, 8, 3, 5, 32, 32, 0, 0, 0};
    dr = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    ex = '{32'h8040c020, 32'h01020304, 32'he92910eb, 32'h04030201, 32'hd70a4497, 32'h00000001, 0, 0, 0};
    for (int v = 6; v < 9; v++) begin
      d[v] = $urandom; s[v] = $urandom_range(2, 31); ex[v] = model(d[v], s[v], 1'b1);
    end
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      set_req(0, d[v], s[v], dr[v]); req_valid = 4'b0001; rsp_ready = 1'b1;
      n = 0;
      #1 while (req_ready !== 4'b0001 && n < 20) begin @(negedge clk); n++; end
      n_checks++;
      if (n >= 20) begin n_errors++; $display("FAIL single_grant_timeout v%0d: got %b want 0001", v, req_ready); end
      sb.push_back('{2'd0, ex[v], 1'b0});
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
        n_errors++;
        $display("FAIL single v%0d s=%0d: got v=%b id=%0d d=%h e=%b want v=1 id=%0d d=%h e=%b",
                 v, s[v], rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d[3]; int s[3]; logic er[3]; logic [31:0] ex[3]; exp_t e;
    d = '{32'h12345678, 32'h04030201, 32'hcafef00d};
    s = '{0, 8, 33};
    er = '{1, 0, 1};
    ex = '{32'h12345678, 32'h01020304, 32'hcafef00d};
    @(negedge clk);
    n_checks++;
    if (err_sticky !== 1'b0) begin n_errors++; $display("FAIL sticky_pre: got %b want 0", err_sticky); end
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      set_req(1, d[v], s[v], 1'b1); req_valid = 4'b0010; rsp_ready = 1'b1;
      #1 n_checks++;
      if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL illegal_grant v%0d: got %b want 0010", v, req_ready); end
      sb.push_back('{2'd1, ex[v], er[v]});
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err, err_sticky} !== {1'b1, e.id, e.data, e.err, 1'b1}) begin
        n_errors++;
        $display("FAIL illegal v%0d s=%0d: got v=%b id=%0d d=%h e=%b sticky=%b want id=%0d d=%h e=%b sticky=1",
                 v, s[v], rsp_valid, rsp_id, rsp_data, rsp_err, err_sticky, e.id, e.data, e.err);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'hA0A0_0000 + i, 8, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) req_valid = '0; else req_valid = 4'b1111;
      #1;
      if (k > 0) begin
        e = sb.pop_front();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
          n_errors++;
          $display("FAIL rr_rsp k%0d: got v=%b id=%0d d=%h want id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
      end
      n_checks++;
      if (job_count !== 16'(k)) begin n_errors++; $display("FAIL rr_job k%0d: got %0d want %0d", k, job_count, k); end
      if (k < 8) begin
        n_checks++;
        if (req_ready !== 4'(1 << (k % 4))) begin
          n_errors++; $display("FAIL rr_grant k%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
        end
        sb.push_back('{2'(k % 4), 32'hA0A0_0000 + (k % 4), 1'b0});
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; logic [31:0] hold_d; logic [1:0] hold_id;
    @(negedge clk);
    set_req(2, 32'h5555_aaaa, 4, 1'b1); req_valid = 4'b0100; rsp_ready = 1'b0;
    sb.push_back('{2'd2, model(32'h5555_aaaa, 4, 1'b1), 1'b0});
    @(posedge clk); #1 req_valid = '0;
    set_req(1, 32'h0f0f_1234, 16, 1'b1); req_valid = 4'b0010;
    hold_d = rsp_data; hold_id = rsp_id;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_id} !== {4'b0000, 1'b1, hold_d, hold_id}) begin
        n_errors++;
        $display("FAIL bp_hold c%0d: got rdy=%b v=%b d=%h id=%0d want rdy=0000 v=1 d=%h id=%0d",
                 c, req_ready, rsp_valid, rsp_data, rsp_id, hold_d, hold_id);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_release_grant: got %b want 0010", req_ready); end
    e = sb.pop_front();
    n_checks++;
    if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
      n_errors++; $display("FAIL bp_first: got id=%0d d=%h want id=%0d d=%h", rsp_id, rsp_data, e.id, e.data);
    end
    sb.push_back('{2'd1, model(32'h0f0f_1234, 16, 1'b1), 1'b0});
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
      n_errors++; $display("FAIL bp_second: got v=%b id=%0d d=%h want id=%0d d=%h", rsp_valid, rsp_id, rsp_data, e.id, e.data);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(1, 32'h1111_2222, 0, 1'b1); req_valid = 4'b0010; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_err, err_sticky} !== 3'b111) begin
      n_errors++; $display("FAIL rstmid_pre: got v=%b e=%b s=%b want 111", rsp_valid, rsp_err, err_sticky);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, job_count, err_sticky, rsp_data} !== '0) begin
      n_errors++; $display("FAIL rstmid_post: got v=%b jc=%0d s=%b d=%h want zeros", rsp_valid, job_count, err_sticky, rsp_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h0, 8, 1'b0);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1 n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL rstmid_grant: got %b want 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(0, 32'h0, 8, 1'b1); req_valid = 4'b0001; rsp_ready = 1'b1;
    repeat (16'hFFFF) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (job_count !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_preload: got %h want ffff", job_count); end
    req_valid = 4'b0001;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (job_count !== 16'h0000) begin n_errors++; $display("FAIL wrap: got %h want 0000", job_count); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_slice = '0; req_dir = '0; rsp_ready = 1'b1;
    test_reset();
    test_single_requests();
    test_illegal();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
